// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for a bank of common-anode
// seven-segment digits on a shared segment bus. Display contents are held in
// shadow registers that are loaded atomically; a prescaler/digit index scans
// the digits with one dead-time cycle per digit to avoid ghosting. Per-digit
// enable and blink, BCD/hex decoding and leading-zero suppression decide
// whether a digit shows its glyph or is blanked.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1024,
  parameter int BLINK_DIV  = 16,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   enable_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    lz_suppress_i,
  output logic [6:0]              seg_n_o,
  output logic [NUM_DIGITS-1:0]   dig_n_o,
  output logic                    frame_o
);

  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  // Active-low glyph for one nibble; unknown codes stay dark.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Shadow (displayed) contents
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   enable_q, enable_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic                    lz_q, lz_d;

  // Scan state
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Registered outputs
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
  logic                  frame_q, frame_d;

  // Decode helpers
  logic [NUM_DIGITS-1:0] lz_vec_s;
  logic                  all_zero_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_en_s;
  logic                  cur_blink_s;
  logic                  cur_lz_s;
  logic                  blank_s;

  // Shadow next-state: all fields replaced together on load, held otherwise.
  always_comb begin
    value_d  = value_q;
    enable_d = enable_q;
    blink_d  = blink_q;
    lz_d     = lz_q;
    if (load_i) begin
      value_d  = value_i;
      enable_d = enable_i;
      blink_d  = blink_i;
      lz_d     = lz_suppress_i;
    end else begin
      value_d  = value_q;
      enable_d = enable_q;
      blink_d  = blink_q;
      lz_d     = lz_q;
    end
  end

  // Prescaler, digit index, frame counter and blink phase next-state.
  always_comb begin
    p_d     = p_q;
    k_d     = k_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (p_q == P_LAST) begin
      p_d = '0;
      if (k_q == K_LAST) begin
        k_d = '0;
        if (fcnt_q == B_LAST) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end else begin
      p_d = p_q + 1'b1;
    end
  end

  // Leading-zero mask: a digit is suppressed when it and every digit above it are zero.
  always_comb begin
    all_zero_s = 1'b1;
    lz_vec_s   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero_s  = all_zero_s & (value_q[4*i +: 4] == 4'h0);
      lz_vec_s[i] = lz_q & all_zero_s & (i != 0);
    end
  end

  // Pick the shadow fields of the currently selected digit.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_en_s    = 1'b0;
    cur_blink_s = 1'b0;
    cur_lz_s    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_nib_s   = (k_q == KW'(i)) ? value_q[4*i +: 4] : cur_nib_s;
      cur_en_s    = (k_q == KW'(i)) ? enable_q[i]       : cur_en_s;
      cur_blink_s = (k_q == KW'(i)) ? blink_q[i]        : cur_blink_s;
      cur_lz_s    = (k_q == KW'(i)) ? lz_vec_s[i]       : cur_lz_s;
    end
  end

  // Output next-state for the current (k,p); dead time when p is zero.
  always_comb begin
    blank_s = ~cur_en_s
            | (cur_blink_s & phase_q)
            | ((HEX_EN == 1'b0) && (cur_nib_s > 4'h9))
            | cur_lz_s;
    if ((p_q == '0) || blank_s) begin
      seg_n_d = 7'h7F;
    end else begin
      seg_n_d = glyph(cur_nib_s);
    end
    dig_n_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_n_d[i] = ~((p_q != '0) && (k_q == KW'(i)));
    end
    frame_d = (p_q == '0) && (k_q == '0);
  end

  // Shadow registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      value_q  <= '0;
      enable_q <= '0;
      blink_q  <= '0;
      lz_q     <= 1'b0;
    end else begin
      value_q  <= value_d;
      enable_q <= enable_d;
      blink_q  <= blink_d;
      lz_q     <= lz_d;
    end
  end

  // Scan state registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      p_q     <= '0;
      k_q     <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      k_q     <= k_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // Output registers; dark and deselected while in reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      seg_n_q <= 7'h7F;
      dig_n_q <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_n_q <= seg_n_d;
      dig_n_q <= dig_n_d;
      frame_q <= frame_d;
    end
  end

  assign seg_n_o = seg_n_q;
  assign dig_n_o = dig_n_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2. One instance decodes hex, a second one blanks hex codes; both
// share the same stimulus. Expected glyphs are hand-written constants.
module tb_seven_segment_scanner;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  enable_i;
  logic [3:0]  blink_i;
  logic        lz_i;

  logic [6:0]  seg_h, seg_x;
  logic [3:0]  dig_h, dig_x;
  logic        frame_h, frame_x;

  int n_checks = 0;
  int n_errors = 0;

  // 10 ns system clock
  always #5 clock = ~clock;

  seven_segment_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .HEX_EN(1'b1)
  ) u_hex (
    .clock_i(clock), .reset_i(reset_i), .load_i(load_i), .value_i(value_i),
    .enable_i(enable_i), .blink_i(blink_i), .lz_suppress_i(lz_i),
    .seg_n_o(seg_h), .dig_n_o(dig_h), .frame_o(frame_h)
  );

  seven_segment_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .HEX_EN(1'b0)
  ) u_nohex (
    .clock_i(clock), .reset_i(reset_i), .load_i(load_i), .value_i(value_i),
    .enable_i(enable_i), .blink_i(blink_i), .lz_suppress_i(lz_i),
    .seg_n_o(seg_x), .dig_n_o(dig_x), .frame_o(frame_x)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset, then release with load held so the new contents are in place
  // from frame 0; returns at frame 0, output cycle 0.
  task automatic do_reset(input logic [15:0] v, input logic [3:0] en,
                          input logic [3:0] bl, input logic lz);
    value_i  = v;
    enable_i = en;
    blink_i  = bl;
    lz_i     = lz;
    load_i   = 1'b1;
    reset_i  = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    step();
    load_i = 1'b0;
  endtask

  // Check one full 16-cycle frame starting at its output cycle 0, then
  // advance to the next frame's output cycle 0.
  task automatic check_frame(input bit hex, input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3, input string tag);
    logic [6:0] g [4];
    logic [6:0] es;
    logic [3:0] ed;
    logic [3:0] one;
    int d;
    int ph;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    one = 4'b0001;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      d  = j / 4;
      ph = j % 4;
      ed = (ph == 0) ? 4'hF : ~(one << d);
      es = (ph == 0) ? 7'h7F : g[d];
      chk($sformatf("%s seg c%0d", tag, j), hex ? seg_h : seg_x, es);
      chk($sformatf("%s dig c%0d", tag, j), hex ? dig_h : dig_x, ed);
      chk($sformatf("%s frame c%0d", tag, j), hex ? frame_h : frame_x, (j == 0) ? 1 : 0);
    end
    step();
  endtask

  initial begin
    logic [6:0] es;
    logic [6:0] old_g [4];
    logic [6:0] new_g [4];
    logic [3:0] ed;
    logic [3:0] one;
    int d;
    int ph;

    reset_i  = 1'b1;
    load_i   = 1'b0;
    value_i  = 16'h0000;
    enable_i = 4'h0;
    blink_i  = 4'h0;
    lz_i     = 1'b0;
    one      = 4'b0001;
    step(); step(); step();

    // Reset values
    chk("rst seg", seg_h, 7'h7F);
    chk("rst dig", dig_h, 4'hF);
    chk("rst frame", frame_h, 1'b0);
    chk("rst seg nohex", seg_x, 7'h7F);

    // Empty display after reset: scan pattern with dark segments
    do_reset(16'h0000, 4'h0, 4'h0, 1'b0);
    check_frame(1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "rst_seq");

    // Load and scan
    do_reset(16'h1234, 4'hF, 4'h0, 1'b0);
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "scan0");
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "scan1");
    check_frame(1'b0, 7'h19, 7'h30, 7'h24, 7'h79, "scan_nohex");

    // Asynchronous reset mid-frame, held for a further edge
    step(); step(); step(); step(); step();
    #3;
    reset_i = 1'b1;
    #1;
    chk("mid rst seg", seg_h, 7'h7F);
    chk("mid rst dig", dig_h, 4'hF);
    chk("mid rst frame", frame_h, 1'b0);
    chk("mid rst dig nohex", dig_x, 4'hF);
    step();
    chk("held rst seg", seg_h, 7'h7F);
    chk("held rst dig", dig_h, 4'hF);

    // Leading-zero suppression
    do_reset(16'h0070, 4'hF, 4'h0, 1'b1);
    check_frame(1'b1, 7'h40, 7'h78, 7'h7F, 7'h7F, "lz_0070");
    do_reset(16'h0000, 4'hF, 4'h0, 1'b1);
    check_frame(1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F, "lz_0000");
    do_reset(16'h0070, 4'hF, 4'h0, 1'b0);
    check_frame(1'b1, 7'h40, 7'h78, 7'h40, 7'h40, "nolz_0070");

    // Hex decoding on and off
    do_reset(16'hABCD, 4'hF, 4'h0, 1'b0);
    check_frame(1'b1, 7'h21, 7'h46, 7'h03, 7'h08, "hex_on");
    check_frame(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "hex_off");

    // Per-digit enable
    do_reset(16'h1234, 4'b1010, 4'h0, 1'b0);
    check_frame(1'b1, 7'h7F, 7'h30, 7'h7F, 7'h79, "enable");

    // Blink on digit 0: frames 0-1 lit, 2-3 dark, 4-5 lit
    do_reset(16'h1234, 4'hF, 4'b0001, 1'b0);
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "blink_f0");
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "blink_f1");
    check_frame(1'b1, 7'h7F, 7'h30, 7'h24, 7'h79, "blink_f2");
    check_frame(1'b1, 7'h7F, 7'h30, 7'h24, 7'h79, "blink_f3");
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "blink_f4");
    check_frame(1'b1, 7'h19, 7'h30, 7'h24, 7'h79, "blink_f5");

    // Load on the edge where digit 1 hands over to digit 2
    old_g[0] = 7'h19; old_g[1] = 7'h30; old_g[2] = 7'h24; old_g[3] = 7'h79;
    new_g[0] = 7'h00; new_g[1] = 7'h78; new_g[2] = 7'h02; new_g[3] = 7'h12;
    do_reset(16'h1234, 4'hF, 4'h0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      d  = j / 4;
      ph = j % 4;
      ed = (ph == 0) ? 4'hF : ~(one << d);
      if (ph == 0) begin
        es = 7'h7F;
      end else if (d < 2) begin
        es = old_g[d];
      end else begin
        es = new_g[d];
      end
      chk($sformatf("atom seg c%0d", j), seg_h, es);
      chk($sformatf("atom dig c%0d", j), dig_h, ed);
      if (j == 6) begin
        value_i = 16'h5678;
        load_i  = 1'b1;
      end
      if (j == 7) load_i = 1'b0;
    end
    step();
    check_frame(1'b1, 7'h00, 7'h78, 7'h02, 7'h12, "atom_next");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits sharing one segment bus. It is the parametrised successor of the static per-digit decoder. It adds:
- a digit count set by parameter;
- BCD or hex decoding;
- per-digit enable and blink;
- leading-zero suppression;
- dead-time between digits to prevent ghosting;
- atomic loading of display contents.

It sits between datapath result registers and the board's segment/digit-select pins.

## Interface
- NUM_DIGITS, 8: digits scanned, 1..16.
- SCAN_DIV, 1024: clocks each digit is selected; must be ≥ 2.
- BLINK_DIV, 16: scan frames per blink half-period; must be ≥ 1.
- HEX_EN, 1: 1 decodes 0xA–0xF as hex glyphs; 0 blanks them.

- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  strobe; captures value/enable/blink/lz_suppress into shadow registers.
- value  input  4*NUM_DIGITS  nibble i is digit i; digit 0 is rightmost.
- enable  input  NUM_DIGITS  per-digit on (1) / blank (0).
- blink  input  NUM_DIGITS  per-digit blink enable.
- lz_suppress  input  1  blank leading zero digits.
- seg_n  output  7  active-low segments; bit0=a … bit6=g.
- dig_n  output  NUM_DIGITS  active-low one-hot digit select.
- frame  output  1  one-cycle pulse at start of each scan frame.

## Operation
- **Shadow registers**
  - Shadow value/enable/blink/lz are updated together on any clock with load=1.
  - Inputs are ignored otherwise.
  - The display always renders shadows only.
- **Prescaler and digit index**
  - Prescaler p counts 0..SCAN_DIV-1.
  - At p=SCAN_DIV-1, p wraps to 0 and digit index k advances; k wraps NUM_DIGITS-1 → 0.
  - Frame period = NUM_DIGITS*SCAN_DIV clocks.
- **Blink**
  - Frame counter counts 0..BLINK_DIV-1. On its wrap, blink_phase toggles.
  - blink_phase=0 is visible.
- **Dead time**
  - While p=0, all digit selects are off (dig_n all ones).
  - For p=1..SCAN_DIV-1, dig_n has bit k low only.
- **Blanking.** Digit k shows seg_n=7'h7F if any of the following holds:
  - enable[k]=0;
  - blink[k]=1 and blink_phase=1;
  - HEX_EN=0 and value nibble > 9;
  - leading-zero suppressed.
- **Leading-zero suppression.** Digit k>0 is suppressed when lz=1 and nibbles NUM_DIGITS-1 down to k are all 0. Digit 0 is never suppressed.
- **Glyphs (active-low, hex)**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- **Reset values**
  - p=0, k=0, frame counter 0, blink_phase 0.
  - All shadows 0.
  - seg_n=7'h7F, dig_n all ones, frame=0.
- **Asynchronous reset mid-frame.** Outputs go to reset values immediately and stay there while reset is high. The first frame restarts at k=0, p=0 on the first clock after deassertion.
- **Output latency.** seg_n, dig_n and frame are registered. The output for state (k,p) appears one clock after that state.
- **frame** is high for exactly one clock, coincident with the dead-time output cycle of digit 0.
- **Load latency.** A load at edge t updates shadows at t. The new contents appear on outputs from edge t+1 for whichever digit is then selected.
  - No partial update across digits within one load.
  - A load on the same clock as a digit advance is not lost.
- **Blink latency.** blink_phase toggles at the edge where the frame counter wraps. Its effect is visible from the next frame's first output cycle.
- **NUM_DIGITS=1.** k stays 0 and frame pulses every SCAN_DIV clocks.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
- **Reset.** Assert reset mid-frame.
  - Required: same cycle, seg_n=7F, dig_n=F, frame=0.
  - After release, with no load: dig_n sequences F,E,E,E,F,D,D,D,… and seg_n stays 7F.
- **Load and scan.** load with value=16'h1234, enable=F, lz=0.
  - Digit 0: outputs F/7F for 1 cycle, then dig_n=E with seg_n=19 for 3 cycles.
  - Then digit 1 (dig_n=D, seg_n=30), digit 2 (B, 24), digit 3 (7, 79).
  - frame pulses every 16 clocks.
- **Leading-zero suppression.** value=16'h0070, lz=1.
  - Required: digits 3, 2 → 7F; digit 1 → 78; digit 0 → 40.
  - value=0 → digits 3..1 blank, digit 0 → 40.
- **Hex mode.** value=16'hABCD.
  - HEX_EN=1: digits 0..3 → 21, 46, 03, 08.
  - HEX_EN=0: all 7F.
- **Blink.** blink=4'b0001, enable=F.
  - Required: digit 0 glyph visible in frames 0–1, 7F in frames 2–3, visible in frames 4–5.
  - Digits 1–3 are unaffected.
- **Load atomicity.** Assert load on the clock where p wraps and k advances 1→2.
  - Required: the digit 2 output cycle following that edge already shows the new nibble.
  - The old digit 1 output is not altered retroactively.
